// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM encoding and width helper for the SPI burst sender.
//   state_e   : IDLE / SHIFT / GAP
//   cnt_width : counter width for a modulus, never below one bit
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_e;

    function automatic int cnt_width(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: DUTY-cycle divider producing DCLK and its edge strobes.
//   clk_in, rst_in : system clock, synchronous active-high reset
//   run_i          : counter runs (SHIFT or GAP), otherwise held at zero
//   shift_i        : DCLK may toggle (SHIFT only)
//   dclk_o         : divided clock, idles low
//   tick_o         : last cycle of a DUTY interval
//   rise_o, fall_o : DCLK will rise / fall on the next edge
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int DUTY = 50
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic run_i,
    input  logic shift_i,
    output logic dclk_o,
    output logic tick_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = cnt_width(DUTY);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          dclk_q, dclk_d;

    assign tick_o = cnt_q == CW'(DUTY - 1);
    assign rise_o = shift_i && tick_o && !dclk_q;
    assign fall_o = shift_i && tick_o && dclk_q;
    assign dclk_o = dclk_q;

    always_comb begin
        cnt_d  = !run_i || tick_o ? '0 : cnt_q + CW'(1);
        dclk_d = shift_i && tick_o ? !dclk_q : dclk_q;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q  <= '0;
            dclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dclk_q <= dclk_d;
        end
    end

endmodule

// File: rtl/spi_burst_send.sv
// spi_burst_send: serialises DATA_WIDTH-bit words onto LINES parallel CIPO
//   lines, MSB chunk first, with a generated DCLK and an active-low CS.
//   clk_in, rst_in                  : system clock, synchronous active-high reset
//   data_in, data_valid_in, last_in,
//   mute_in, data_ready_out         : word handshake (accept on valid && ready)
//   chip_data_out, chip_clk_out,
//   chip_sel_out                    : SPI pins (data, DCLK, CS active-low)
//   busy_out                        : high whenever not IDLE
//   frame_done_out                  : one-cycle pulse as CS rises after a last word
module spi_burst_send
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int LINES           = 4,
    parameter int DATA_CLK_PERIOD = 100,
    parameter int CONTINUOUS      = 0
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid_in,
    input  logic                  last_in,
    input  logic                  mute_in,
    output logic                  data_ready_out,
    output logic [LINES-1:0]      chip_data_out,
    output logic                  chip_clk_out,
    output logic                  chip_sel_out,
    output logic                  busy_out,
    output logic                  frame_done_out
);

    localparam int BEATS = DATA_WIDTH / LINES;
    localparam int DUTY  = DATA_CLK_PERIOD / 2;
    localparam int BW    = cnt_width(BEATS + 1);

    if (DATA_WIDTH % LINES != 0 || DATA_CLK_PERIOD < 2 || DATA_CLK_PERIOD % 2 != 0) begin : g_bad_params
        $error("spi_burst_send: DATA_WIDTH must be a multiple of LINES and DATA_CLK_PERIOD even and >= 2");
    end

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] sh_q, sh_d;
    logic [BW-1:0]         beat_q, beat_d;
    logic                  last_q, last_d;
    logic                  cs_q, cs_d;
    logic                  done_q, done_d;
    logic                  dclk, tick, rise, fall;
    logic                  accept, final_fall;

    spi_clk_gen #(.DUTY(DUTY)) u_clk_gen (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .run_i   (state_q != IDLE),
        .shift_i (state_q == SHIFT),
        .dclk_o  (dclk),
        .tick_o  (tick),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    // Beats are counted as the receiver samples them (DCLK rise); the fall
    // after the BEATS-th rise closes the word.
    assign final_fall     = state_q == SHIFT && fall && beat_q == BW'(BEATS);
    // In continuous mode the next word may join on the closing fall, unless
    // the current word ends a frame.
    assign data_ready_out = !rst_in && (state_q == IDLE ||
                            (CONTINUOUS != 0 && final_fall && !last_q));
    assign accept         = data_valid_in && data_ready_out;

    assign chip_data_out  = sh_q[DATA_WIDTH-1 -: LINES];
    assign chip_clk_out   = dclk;
    assign chip_sel_out   = cs_q;
    assign busy_out       = !rst_in && state_q != IDLE;
    assign frame_done_out = !rst_in && done_q;

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        beat_d  = beat_q;
        last_d  = last_q;
        cs_d    = cs_q;
        done_d  = 1'b0;
        if (accept) begin
            state_d = SHIFT;
            sh_d    = mute_in ? '0 : data_in;
            beat_d  = '0;
            last_d  = last_in;
            cs_d    = 1'b0;
        end else if (final_fall) begin
            // Last chunk stays on the pins through GAP.
            state_d = GAP;
            cs_d    = 1'b1;
            done_d  = last_q;
        end else if (state_q == SHIFT) begin
            beat_d = rise ? beat_q + BW'(1) : beat_q;
            sh_d   = fall ? sh_q << LINES : sh_q;
        end else if (state_q == GAP && tick) begin
            state_d = IDLE;
            sh_d    = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            sh_q    <= '0;
            beat_q  <= '0;
            last_q  <= 1'b0;
            cs_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            beat_q  <= beat_d;
            last_q  <= last_d;
            cs_q    <= cs_d;
            done_q  <= done_d;
        end
    end

endmodule
